ap_txn_profiler: RTL

Synthesizable per-module transaction profiler for HLS `ap_ctrl_hs`-style blocks. It is the stage that consumes the same `ap_start/ap_ready/ap_done/ap_continue` signals the co-simulation status monitors sample. It converts each completed handshake into one timing record (latency, interval, ready latency, continue-stall) and buffers records in a small FIFO behind a valid/ready port, so a dumper or debug bus can drain them on-chip.

---
 rtl/ap_txn_profiler_pkg.sv | 36 +++
 rtl/ap_txn_profiler_if.sv | 30 +++
 rtl/ap_txn_profiler_fifo.sv | 45 ++++
 rtl/ap_txn_profiler.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ap_txn_profiler_pkg.sv
// Shared types and the saturating arithmetic used by the transaction profiler.
package ap_prof_pkg;

    localparam int PROF_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DWAIT = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [PROF_CNT_W-1:0] latency;
        logic [PROF_CNT_W-1:0] interval;
        logic [PROF_CNT_W-1:0] ready_lat;
        logic [PROF_CNT_W-1:0] stall;
        logic                  incomplete;
    } prof_rec_t;

    // Add (sub=0) clamps at all-ones; subtract (sub=1) clamps at zero.
    function automatic logic [PROF_CNT_W-1:0] sat_op(
        input logic [PROF_CNT_W-1:0] a,
        input logic [PROF_CNT_W-1:0] b,
        input logic                  sub
    );
        logic [PROF_CNT_W:0] r;
        if (sub) begin
            r = {1'b0, a} - {1'b0, b};
            return r[PROF_CNT_W] ? '0 : r[PROF_CNT_W-1:0];
        end
        r = {1'b0, a} + {1'b0, b};
        return r[PROF_CNT_W] ? '1 : r[PROF_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/ap_txn_profiler_if.sv
// Observed ap_ctrl_hs handshake plus the record stream leaving the profiler.
interface ap_txn_profiler_if #(
    parameter int CNT_W = 32
);
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic             rec_valid;
    logic             rec_ready;
    logic [CNT_W-1:0] rec_latency;
    logic [CNT_W-1:0] rec_interval;
    logic [CNT_W-1:0] rec_ready_lat;
    logic [CNT_W-1:0] rec_stall;
    logic             rec_incomplete;

    // Profiler side: observes the handshake, sources records.
    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue, rec_ready,
        output rec_valid, rec_latency, rec_interval, rec_ready_lat,
               rec_stall, rec_incomplete
    );

    // Environment side: drives the handshake, drains records.
    modport master (
        output ap_start, ap_ready, ap_done, ap_continue, rec_ready,
        input  rec_valid, rec_latency, rec_interval, rec_ready_lat,
               rec_stall, rec_incomplete
    );
endinterface

// File: rtl/ap_txn_profiler_fifo.sv
// Synchronous record FIFO; head is a registered slot so fields stay stable until popped.
module prof_rec_fifo
    import ap_prof_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  prof_rec_t i_data,
    input  logic      i_pop,
    output prof_rec_t o_head,
    output logic      o_full,
    output logic      o_empty
);
    localparam int AW = $clog2(DEPTH);

    prof_rec_t       r_mem [DEPTH];
    logic [AW:0]     r_wr;
    logic [AW:0]     r_rd;
    logic            w_pop;
    logic            w_push;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = i_pop & ~o_empty;
    // When full, a same-cycle pop frees the head slot, which is exactly the write slot.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_head  = r_mem[r_rd[AW-1:0]];

    // Pointer and storage update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr[AW-1:0]] <= i_data;
                r_wr                <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
        end
    end
endmodule

// File: rtl/ap_txn_profiler.sv
// Per-module ap_ctrl_hs profiler: turns each handshake into one timing record.
module ap_txn_profiler
    import ap_prof_pkg::*;
#(
    parameter int CNT_W = PROF_CNT_W,
    parameter int DEPTH = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_finish,
    ap_txn_profiler_if.slave        bus,
    output logic [CNT_W-1:0]        o_txn_count,
    output logic [CNT_W-1:0]        o_drop_count,
    output logic                    o_overflow,
    output logic                    o_busy
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cyc, r_st, r_prev_st, r_interval, r_rdy_lat, r_lat, r_stall;
    logic [CNT_W-1:0] w_st_n, w_prev_n, w_int_n, w_rl_n, w_lat_n, w_stall_n, w_lat;
    logic [CNT_W-1:0] r_txn, r_drop;
    logic             r_have_prev, r_rdy_seen, r_ovf, r_busy;
    logic             w_have_n, w_rs_n, w_in_run;
    logic             w_push, w_pop, w_accept, w_full, w_empty;
    prof_rec_t        w_rec, w_head;

    assign w_pop    = ~w_empty & bus.rec_ready;
    assign w_accept = ~w_full | w_pop;

    // Next-state and record assembly.
    always_comb begin
        w_state_n = r_state;
        w_st_n    = r_st;
        w_prev_n  = r_prev_st;
        w_have_n  = r_have_prev;
        w_int_n   = r_interval;
        w_rl_n    = r_rdy_lat;
        w_rs_n    = r_rdy_seen;
        w_lat_n   = r_lat;
        w_stall_n = r_stall;
        w_push    = 1'b0;
        w_rec     = '0;
        w_in_run  = 1'b0;

        // A start opens the transaction in this same cycle so done/ready can land on it.
        if (r_state == IDLE && !i_finish && bus.ap_start) begin
            w_st_n    = r_cyc;
            w_int_n   = r_have_prev ? sat_op(r_cyc, r_prev_st, 1'b1) : '0;
            w_prev_n  = r_cyc;
            w_have_n  = 1'b1;
            w_rl_n    = '0;
            w_rs_n    = 1'b0;
            w_stall_n = '0;
            w_state_n = RUN;
            w_in_run  = 1'b1;
        end
        if (r_state == RUN) w_in_run = 1'b1;

        // Inclusive cycle count from the start cycle to now.
        w_lat = sat_op(sat_op(r_cyc, w_st_n, 1'b1), ONE, 1'b0);

        if (i_finish) begin
            w_state_n = HALT;
            if (r_state == RUN || r_state == DWAIT) begin
                w_push           = 1'b1;
                w_rec.latency    = w_lat;
                w_rec.interval   = r_interval;
                w_rec.ready_lat  = r_rdy_lat;
                w_rec.stall      = (r_state == DWAIT) ? r_stall : '0;
                w_rec.incomplete = 1'b1;
            end
        end else if (w_in_run) begin
            if (bus.ap_ready && !w_rs_n) begin
                w_rs_n = 1'b1;
                w_rl_n = w_lat;
            end
            if (bus.ap_done) begin
                if (bus.ap_continue) begin
                    w_push          = 1'b1;
                    w_rec.latency   = w_lat;
                    w_rec.interval  = w_int_n;
                    w_rec.ready_lat = w_rl_n;
                    w_state_n       = IDLE;
                end else begin
                    w_lat_n   = w_lat;
                    w_stall_n = ONE;
                    w_state_n = DWAIT;
                end
            end
        end else if (r_state == DWAIT) begin
            // Stall counts every cycle done was held, including the releasing one.
            w_stall_n = sat_op(r_stall, ONE, 1'b0);
            if (bus.ap_continue) begin
                w_push          = 1'b1;
                w_rec.latency   = r_lat;
                w_rec.interval  = r_interval;
                w_rec.ready_lat = r_rdy_lat;
                w_rec.stall     = w_stall_n;
                w_state_n       = IDLE;
            end
        end
    end

    // State, transaction context and statistics registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_cyc       <= '0;
            r_st        <= '0;
            r_prev_st   <= '0;
            r_have_prev <= 1'b0;
            r_interval  <= '0;
            r_rdy_lat   <= '0;
            r_rdy_seen  <= 1'b0;
            r_lat       <= '0;
            r_stall     <= '0;
            r_txn       <= '0;
            r_drop      <= '0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cyc       <= sat_op(r_cyc, ONE, 1'b0);
            r_st        <= w_st_n;
            r_prev_st   <= w_prev_n;
            r_have_prev <= w_have_n;
            r_interval  <= w_int_n;
            r_rdy_lat   <= w_rl_n;
            r_rdy_seen  <= w_rs_n;
            r_lat       <= w_lat_n;
            r_stall     <= w_stall_n;
            r_busy      <= (w_state_n == RUN) || (w_state_n == DWAIT);
            if (w_push) begin
                r_txn <= sat_op(r_txn, ONE, 1'b0);
                if (!w_accept) begin
                    r_drop <= sat_op(r_drop, ONE, 1'b0);
                    r_ovf  <= 1'b1;
                end
            end
        end
    end

    prof_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clock),
        .i_rst   (i_reset),
        .i_push  (w_push & w_accept),
        .i_data  (w_rec),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.rec_valid      = ~w_empty;
    assign bus.rec_latency    = w_head.latency;
    assign bus.rec_interval   = w_head.interval;
    assign bus.rec_ready_lat  = w_head.ready_lat;
    assign bus.rec_stall      = w_head.stall;
    assign bus.rec_incomplete = w_head.incomplete;
    assign o_txn_count        = r_txn;
    assign o_drop_count       = r_drop;
    assign o_overflow         = r_ovf;
    assign o_busy             = r_busy;
endmodule
